// File: rtl/display_pkg.sv
// Shared definitions for the character display buffer: FSM states,
// default character codes and the cell-address width helper.
package display_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam logic [7:0] CARET_CHR_DEF = 8'h5F;
  localparam logic [7:0] BLANK_CHR_DEF = 8'h20;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/display_buffer_if.sv
// Command, read and status signals of the display buffer, bundled so the
// producer (master) and the buffer (slave) see matching directions.
interface display_buffer_if
  import display_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int AW = addr_w(DEPTH);

  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic              i_clear;
  logic              i_bksp;
  logic              i_rd_en;
  logic [AW-1:0]     i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic [AW-1:0]     o_cursor;
  logic              o_full;

  modport master (
    output i_wr_valid, i_wr_data, i_clear, i_bksp, i_rd_en, i_rd_addr,
    input  o_wr_ready, o_rd_data, o_rd_valid, o_cursor, o_full
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_clear, i_bksp, i_rd_en, i_rd_addr,
    output o_wr_ready, o_rd_data, o_rd_valid, o_cursor, o_full
  );
endinterface

// File: rtl/blink_gen.sv
// Caret blink divider: counts BLINK_DIV clocks per half-period and flips
// the phase each time the count wraps.
module blink_gen #(
  parameter int BLINK_DIV = 6_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_phase
);
  localparam int            CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] WRAP = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // NOTE: every signal assigned here gets a default first, so no path can hold a stale value and infer a latch.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == WRAP) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign o_phase = phase_q;
endmodule

// File: rtl/display_buffer.sv
// Character display buffer: cell storage with cursor, scroll/wrap on
// overflow, backspace, blank-fill pass and a blinking caret on reads.
module display_buffer
  import display_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CARET_CHR = DATA_W'(CARET_CHR_DEF),
  parameter logic [DATA_W-1:0] BLANK_CHR = DATA_W'(BLANK_CHR_DEF),
  parameter int                BLINK_DIV = 6_000_000,
  parameter int                SCROLL_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  display_buffer_if.slave bus
);
  localparam int            AW   = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic [AW-1:0]     cursor_q, cursor_d;
  logic              full_q, full_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we, scroll;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              blink_phase;
  logic              rd_in_range, caret_hit;
  logic [DATA_W-1:0] rd_word;

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_phase (blink_phase)
  );

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    cursor_d   = cursor_q;
    full_d     = full_q;
    wr_ready_d = wr_ready_q;
    mem_we     = 1'b0;
    scroll     = 1'b0;
    mem_waddr  = clr_idx_q;
    mem_wdata  = BLANK_CHR;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clr_idx_q == LAST) begin
          state_d    = ST_IDLE;
          wr_ready_d = 1'b1;
          clr_idx_d  = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.i_clear) begin
          state_d    = ST_CLEAR;
          wr_ready_d = 1'b0;
          clr_idx_d  = '0;
          cursor_d   = '0;
          full_d     = 1'b0;
        end else if (bus.i_bksp) begin
          // A full line still has its cursor parked on the last written cell.
          if (full_q) begin
            mem_we    = 1'b1;
            mem_waddr = LAST;
            full_d    = 1'b0;
          end else if (cursor_q != '0) begin
            mem_we    = 1'b1;
            mem_waddr = cursor_q - 1'b1;
            cursor_d  = cursor_q - 1'b1;
          end
        end else if (bus.i_wr_valid) begin
          mem_wdata = bus.i_wr_data;
          if (full_q) begin
            if (SCROLL_EN != 0) begin
              scroll = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = '0;
              cursor_d  = AW'(1);
              full_d    = 1'b0;
            end
          end else begin
            mem_we    = 1'b1;
            mem_waddr = cursor_q;
            if (cursor_q == LAST) full_d = 1'b1;
            else                  cursor_d = cursor_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      cursor_q   <= '0;
      full_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      cursor_q   <= cursor_d;
      full_q     <= full_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // NOTE: cell storage has no reset; the CLEAR pass that follows every reset blanks it.
  always_ff @(posedge i_clk) begin
    if (scroll) begin
      for (int k = 0; k < DEPTH - 1; k++) mem_q[k] <= mem_q[k+1];
      mem_q[DEPTH-1] <= mem_wdata;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_in_range = int'(bus.i_rd_addr) < DEPTH;
  assign caret_hit   = (state_q == ST_IDLE) && blink_phase && !full_q &&
                       (bus.i_rd_addr == cursor_q);
  assign rd_word     = !rd_in_range ? BLANK_CHR :
                       caret_hit    ? CARET_CHR : mem_q[bus.i_rd_addr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= BLANK_CHR;
    end else begin
      rd_valid_q <= bus.i_rd_en;
      if (bus.i_rd_en) rd_data_q <= rd_word;
    end
  end

  assign bus.o_wr_ready = wr_ready_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_cursor   = cursor_q;
  assign bus.o_full     = full_q;
endmodule

// File: doc/display_buffer.md
DISPLAY_BUFFER -- requirements
Module: display_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of display character cells (range 2..64).
REQ-002 SHALL have parameter DATA_W, default 8, giving the character code width.
REQ-003 SHALL have parameter CARET_CHR, default 8'h5F, giving the code substituted at the cursor cell during the caret phase.
REQ-004 SHALL have parameter BLANK_CHR, default 8'h20, giving the code used for clear and backspace.
REQ-005 SHALL have parameter BLINK_DIV, default 6_000_000, giving the clock cycles per caret half-period.
REQ-006 SHALL have parameter SCROLL_EN, default 1: 1 = scroll left on overflow, 0 = cursor wraps to cell 0.
REQ-007 i_clk  in  1  sole clock; all logic on the rising edge.
REQ-008 i_rst_n  in  1  asynchronous, active-low reset.
REQ-009 i_wr_valid  in  1  character write request.
REQ-010 i_wr_data  in  DATA_W  character to store at the cursor.
REQ-011 o_wr_ready  out  1  high when a command is accepted this cycle.
REQ-012 i_clear  in  1  start a blank-fill of all cells.
REQ-013 i_bksp  in  1  backspace command.
REQ-014 i_rd_en  in  1  display read strobe.
REQ-015 i_rd_addr  in  AW=$clog2(DEPTH)  cell to read.
REQ-016 o_rd_data  out  DATA_W  read result.
REQ-017 o_rd_valid  out  1  o_rd_data is valid for the read issued last cycle.
REQ-018 o_cursor  out  AW  current cursor cell.
REQ-019 o_full  out  1  last cell is written and the next write will scroll or wrap.

Function
REQ-020 SHALL implement states CLEAR and IDLE; in CLEAR, write BLANK_CHR to cell clr_idx each cycle, with clr_idx running 0..DEPTH-1, then enter IDLE.
REQ-021 SHALL hold o_wr_ready low in CLEAR and high in IDLE; commands presented while o_wr_ready is low SHALL be ignored.
REQ-022 In IDLE, command priority SHALL be i_clear > i_bksp > i_wr_valid; one command at most per cycle.
REQ-023 i_clear accepted SHALL enter CLEAR, set the cursor to 0 and clear o_full.
REQ-024 Write with cursor<DEPTH-1 SHALL store data at the cursor and increment the cursor.
REQ-025 Write with cursor==DEPTH-1 and o_full=0 SHALL store data and set o_full; the cursor stays at DEPTH-1.
REQ-026 Write with o_full=1 and SCROLL_EN=1 SHALL, in one cycle, set mem[k]<=mem[k+1] for k=0..DEPTH-2 and mem[DEPTH-1]<=data; o_full stays 1.
REQ-027 Write with o_full=1 and SCROLL_EN=0 SHALL store data at cell 0, set the cursor to 1 and clear o_full.
REQ-028 Backspace with o_full=1 SHALL write BLANK_CHR at DEPTH-1 and clear o_full, leaving the cursor unchanged.
REQ-029 Backspace with o_full=0 and cursor>0 SHALL decrement the cursor and write BLANK_CHR at the new cursor.
REQ-030 Backspace at cursor 0 with o_full=0 SHALL be a no-op.
REQ-031 Reads SHALL have 1-cycle latency: o_rd_valid is i_rd_en delayed by one cycle; o_rd_data holds its value when i_rd_en=0.
REQ-032 A read of the cursor cell while blink_phase=1, o_full=0 and state IDLE SHALL return CARET_CHR; every other read SHALL return the stored cell.
REQ-033 Reads SHALL be read-before-write: a same-cycle write to the read cell returns the old value.
REQ-034 i_rd_addr>=DEPTH SHALL return BLANK_CHR.
REQ-035 The blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; its width is $clog2(BLINK_DIV).

Reset
REQ-036 Asserting i_rst_n=0 SHALL asynchronously set state=CLEAR, clr_idx=0, cursor=0, o_full=0, o_wr_ready=0, o_rd_valid=0, o_rd_data=BLANK_CHR, blink counter=0 and blink_phase=0.
REQ-037 Cell storage SHALL NOT be reset directly; it is blanked by the CLEAR pass within DEPTH cycles after reset release.
REQ-038 Reset asserted mid-CLEAR or mid-scroll SHALL abort the operation and restart the CLEAR pass from cell 0.

Structure
REQ-039 A shared package display_pkg SHALL hold the state enum (CLEAR, IDLE), the CARET_CHR and BLANK_CHR defaults, and the AW width function.
REQ-040 The blink divider SHALL be a sub-module blink_gen (BLINK_DIV parameter, o_phase output); storage, cursor and FSM stay in display_buffer.

Verification
REQ-041 Release reset, DEPTH=16 -> o_wr_ready=0 for 16 cycles, then 1; a read of every cell returns 8'h20.
REQ-042 Write "ABCD" -> o_cursor=4; reading cell 2 returns 8'h43; with BLINK_DIV=4, reading cell 4 alternates 8'h5F/8'h20 every 4 cycles.
REQ-043 SCROLL_EN=1: write 17 characters 8'h41..8'h51 -> cell 0=8'h42, cell 15=8'h51, o_full=1, o_cursor=15.
REQ-044 SCROLL_EN=0: write 17 characters -> cell 0=8'h51, o_cursor=1, o_full=0.
REQ-045 With cursor=3 -> backspace gives cursor=2 and cell 2=8'h20; backspace at cursor 0 causes no change; i_clear and i_wr_valid in the same cycle -> clear wins and the write is dropped.
REQ-046 Assert reset at the 8th cycle of CLEAR -> clr_idx restarts at 0 and the full 16-cycle blank pass completes.
